// File: rtl/demux_destino.sv
// Output-side demux: drains a show-ahead FIFO through a one-entry holding register
// and steers each word to P0..P3 by its top two bits, honouring almost_full backpressure.
module demux_destino #(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_in,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  pop_in,
    input  logic                  almost_full_P0,
    input  logic                  almost_full_P1,
    input  logic                  almost_full_P2,
    input  logic                  almost_full_P3,
    output logic                  push_P0,
    output logic                  push_P1,
    output logic                  push_P2,
    output logic                  push_P3,
    output logic [DATA_WIDTH-1:0] out_data_P0,
    output logic [DATA_WIDTH-1:0] out_data_P1,
    output logic [DATA_WIDTH-1:0] out_data_P2,
    output logic [DATA_WIDTH-1:0] out_data_P3,
    output logic [CNT_WIDTH-1:0]  cnt_P0,
    output logic [CNT_WIDTH-1:0]  cnt_P1,
    output logic [CNT_WIDTH-1:0]  cnt_P2,
    output logic [CNT_WIDTH-1:0]  cnt_P3,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS  = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t                 state_q, state_next;
    logic                   hold_valid;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic [CNT_WIDTH-1:0]   cnt [4];
    logic [3:0]             af;
    logic [3:0]             push;
    logic [1:0]             dest;
    logic [1:0]             next_dest;
    logic                   next_valid;
    logic                   push_any;
    logic                   pop;

    assign af = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};

    // Strobes are gated by reset so they drop immediately, not at the next edge.
    always_comb begin
        dest = hold_data[DATA_WIDTH-1 -: 2];
        push = '0;
        if (reset && hold_valid && !af[dest]) begin
            push[dest] = 1'b1;
        end
    end

    assign push_any = |push;
    assign pop      = reset & ~empty_in & (~hold_valid | push_any);

    always_comb begin
        next_valid = hold_valid;
        next_dest  = dest;
        if (pop) begin
            next_valid = 1'b1;
            next_dest  = in_data[DATA_WIDTH-1 -: 2];
        end else if (push_any) begin
            next_valid = 1'b0;
        end
        if (!next_valid) begin
            state_next = IDLE;
        end else if (af[next_dest]) begin
            state_next = STALL;
        end else begin
            state_next = PASS;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            state_q <= state_next;
            if (pop) begin
                hold_data  <= in_data;
                hold_valid <= 1'b1;
            end else if (push_any) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (push[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pop_in      = pop;
    assign push_P0     = push[0];
    assign push_P1     = push[1];
    assign push_P2     = push[2];
    assign push_P3     = push[3];
    assign out_data_P0 = push[0] ? hold_data : '0;
    assign out_data_P1 = push[1] ? hold_data : '0;
    assign out_data_P2 = push[2] ? hold_data : '0;
    assign out_data_P3 = push[3] ? hold_data : '0;
    assign cnt_P0      = cnt[0];
    assign cnt_P1      = cnt[1];
    assign cnt_P2      = cnt[2];
    assign cnt_P3      = cnt[3];
    assign state       = state_q;

endmodule

// File: doc/demux_destino.md
Name: demux_destino

Overview:
- Read end of the round-robin path: drains one merged show-ahead FIFO and routes each 10-bit word to one of four output FIFOs (P0..P3).
- Routing uses the destination field in bits [9:8].
- One-entry holding register; respects almost_full backpressure per output; sustains 1 word/cycle when unblocked.
- Keeps per-output 8-bit push counters for the bench and for debug.

Parameters:
- DATA_WIDTH, 10, word width; must be ≥3.
- CNT_WIDTH, 8, width of each per-output push counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- empty_in  input  1  input FIFO empty flag.
- in_data  input  DATA_WIDTH  input FIFO head word; valid whenever empty_in=0 (show-ahead).
- pop_in  output  1  pop strobe to the input FIFO.
- almost_full_P0..almost_full_P3  input  1 each  output FIFO backpressure.
- push_P0..push_P3  output  1 each  push strobe to the output FIFO.
- out_data_P0..out_data_P3  output  DATA_WIDTH each  data to the output FIFO.
- cnt_P0..cnt_P3  output  CNT_WIDTH each  words pushed per output, wrapping.
- state  output  2  00 IDLE, 01 PASS, 10 STALL.

Behaviour:
- Reset: reset=0 asynchronously clears hold_valid, hold_data, all cnt_Px, and the state register.
  - pop_in and every push_Px are gated by reset, so they are 0 immediately while reset=0.
  - out_data_Px read 0 during reset.
- Destination: dest = hold_data[DATA_WIDTH-1:DATA_WIDTH-2]; 0→P0, 1→P1, 2→P2, 3→P3.
- push_Px (combinational) = reset & hold_valid & (dest==x) & ~almost_full_Px.
  - At most one push per cycle.
- out_data_Px = hold_data when push_Px=1, else 0.
- push_any = OR of the four push_Px.
- pop_in (combinational) = reset & ~empty_in & (~hold_valid | push_any).
- Rising edge of clk:
  - pop_in=1: hold_data<=in_data, hold_valid<=1.
  - else push_any=1: hold_valid<=0.
  - else: hold register unchanged.
- Simultaneous push and pop in one cycle: the old word leaves and the new word loads. This gives 1 word/cycle throughput.
- Latency: a word popped at edge N is pushed in cycle N+1 at the earliest. The push is registered into the output FIFO at edge N+1.
- Blocking: a blocked head word (almost_full on its destination) stalls all traffic (no bypass). pop_in stays 0 until that word drains.
  - Words for other outputs wait behind it, which preserves global order.
- almost_full is sampled combinationally each cycle. Deassertion allows the push in that same cycle.
- Counters: cnt_Px increments at every edge where push_Px=1 and wraps from 2^CNT_WIDTH-1 to 0.
- State register, updated each edge from next-cycle values:
  - IDLE when next hold_valid=0.
  - PASS when next hold_valid=1 and the next word is not blocked.
  - STALL when next hold_valid=1 and the destination almost_full is currently asserted.
  - Output state reflects the current cycle; it is informational only.
- empty_in=1 with hold_valid=0: stays in IDLE, no strobes.
- Reset mid-operation: a held word is discarded and not pushed. Counters clear. Pops resume on the first edge after reset returns to 1, provided empty_in=0.
- in_data is ignored whenever empty_in=1.

Test Plan:
- Reset: hold reset=0 for 2 cycles with empty_in=0, in_data=10'h3FF → pop_in=0, all push_Px=0, cnt_Px=0, state=00.
- Streaming: stream 10'h005, 10'h10A, 10'h20F, 10'h314 back-to-back, no almost_full → one push per cycle on P0, P1, P2, P3 in order, data matching. pop_in=1 for 4 consecutive cycles. Each cnt_Px=1.
- Stall and release: almost_full_P2=1, feed 10'h201 then 10'h002 → 10'h201 held, state=10, pop_in=0, push_P0 not asserted. Drop almost_full_P2 → push_P2 with 10'h201 and pop of 10'h002 in the same cycle; next cycle push_P0 with 10'h002.
- Empty gaps: toggle empty_in every cycle with words for P1 → push_P1 on alternate cycles; state alternates PASS/IDLE; no push while hold_valid=0.
- Counter wrap: push 256 words to P3 → cnt_P3 returns to 8'h00. cnt_P0..cnt_P2 stay 0.
- Reset mid-operation: reset=0 while 10'h1AA is held and P1 is stalled → push_P1 never asserts for 10'h1AA; cnt_P1=0. After release, the next word is popped on the first edge.
